// File: rtl/shared_l3_banked.sv
// Shared L3 data array: NUM_PORTS valid/ready requesters into NUM_BANKS
// word-interleaved single-port banks with per-bank round-robin arbitration.
// After reset every bank is zero-filled, one row per cycle, before requests
// are accepted.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   req_valid    per-port request valid
//   req_ready    per-port grant (combinational from valid/addr)
//   req_we       per-port 1 = write, 0 = read
//   req_addr     per-port word address, port p at [p*ADDR_W +: ADDR_W]
//   req_wdata    per-port write data, port p at [p*DATA_W +: DATA_W]
//   rsp_valid    per-port read data valid, one cycle after accept
//   rsp_rdata    per-port read data, zero when rsp_valid is low
//   init_done    zero-fill complete, block serving requests
//   conflict_cnt saturating count of cycles with a stalled valid request
module shared_l3_banked #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned BANK_DEPTH = 32,
  parameter int unsigned DATA_W     = 32,
  localparam int unsigned BANK_W    = $clog2(NUM_BANKS),
  localparam int unsigned ROW_W     = $clog2(BANK_DEPTH),
  localparam int unsigned ADDR_W    = BANK_W + ROW_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req_valid,
  output logic [NUM_PORTS-1:0]          req_ready,
  input  logic [NUM_PORTS-1:0]          req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]          rsp_valid,
  output logic [NUM_PORTS*DATA_W-1:0]   rsp_rdata,
  output logic                          init_done,
  output logic [15:0]                   conflict_cnt
);

  // Width-1 fallbacks keep selectors legal for a single bank / single port.
  localparam int unsigned BSEL_W = (BANK_W > 0) ? BANK_W : 1;
  localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                r_state;
  logic [ROW_W-1:0]      r_row;
  logic                  r_init_done;
  logic [PORT_W-1:0]     r_rr        [NUM_BANKS];
  logic [NUM_PORTS-1:0]  r_rsp_valid;
  logic [BSEL_W-1:0]     r_rsp_bank  [NUM_PORTS];
  logic [15:0]           r_conflict;
  logic [DATA_W-1:0]     r_mem       [NUM_BANKS][BANK_DEPTH];
  logic [DATA_W-1:0]     r_q         [NUM_BANKS];

  logic                  w_run;
  logic                  w_stall;
  logic [ADDR_W-1:0]     w_addr      [NUM_PORTS];
  logic [BSEL_W-1:0]     w_bank      [NUM_PORTS];
  logic [ROW_W-1:0]      w_row       [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_grant;
  logic [NUM_BANKS-1:0]  w_bank_gnt;
  logic [PORT_W-1:0]     w_gnt_port  [NUM_BANKS];
  logic [ROW_W-1:0]      w_gnt_row   [NUM_BANKS];
  logic [NUM_BANKS-1:0]  w_gnt_we;
  logic [DATA_W-1:0]     w_gnt_wdata [NUM_BANKS];

  // (p + k) mod NUM_PORTS for p < NUM_PORTS and k <= NUM_PORTS.
  function automatic logic [PORT_W-1:0] next_port(logic [PORT_W-1:0] p, int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return PORT_W'(s);
  endfunction

  assign w_run = (r_state == StRun);

  // Low address bits pick the bank so consecutive words spread across banks.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_addr[p] = req_addr[p*ADDR_W +: ADDR_W];
      w_bank[p] = BSEL_W'(w_addr[p] % ADDR_W'(NUM_BANKS));
      w_row[p]  = ROW_W'(w_addr[p] / ADDR_W'(NUM_BANKS));
    end
  end

  // Per bank: first requesting port at or after r_rr, scanning upward with wrap.
  always_comb begin
    logic [PORT_W-1:0] scan;
    scan    = '0;
    w_grant = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_bank_gnt[b] = 1'b0;
      w_gnt_port[b] = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        scan = next_port(r_rr[b], unsigned'(k));
        if (w_run && !w_bank_gnt[b] && req_valid[scan] && (w_bank[scan] == BSEL_W'(b))) begin
          w_bank_gnt[b] = 1'b1;
          w_gnt_port[b] = scan;
          w_grant[scan] = 1'b1;
        end
      end
      w_gnt_row[b]   = w_row[w_gnt_port[b]];
      w_gnt_we[b]    = req_we[w_gnt_port[b]];
      w_gnt_wdata[b] = req_wdata[w_gnt_port[b]*DATA_W +: DATA_W];
    end
  end

  assign w_stall   = w_run && ((req_valid & ~w_grant) != '0);
  assign req_ready = w_grant;

  // FSM, arbitration pointers, response steering and the conflict counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StInit;
      r_row       <= '0;
      r_init_done <= 1'b0;
      r_rsp_valid <= '0;
      r_conflict  <= '0;
      for (int b = 0; b < NUM_BANKS; b++) r_rr[b] <= '0;
      for (int p = 0; p < NUM_PORTS; p++) r_rsp_bank[p] <= '0;
    end else begin
      case (r_state)
        StInit: begin
          r_row <= r_row + 1'b1;
          if (r_row == ROW_W'(BANK_DEPTH - 1)) begin
            r_state     <= StRun;
            r_init_done <= 1'b1;
          end
        end
        StRun:   r_state <= StRun;
        default: r_state <= StInit;
      endcase
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_bank_gnt[b]) r_rr[b] <= next_port(w_gnt_port[b], 1);
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_rsp_valid[p] <= w_grant[p] & ~req_we[p];
        r_rsp_bank[p]  <= w_bank[p];
      end
      if (w_stall && (r_conflict != 16'hFFFF)) r_conflict <= r_conflict + 16'd1;
    end
  end

  // Bank RAMs: no reset on the array, the zero-fill sequence clears it.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (!w_run) begin
        r_mem[b][r_row] <= '0;
      end else if (w_bank_gnt[b]) begin
        if (w_gnt_we[b]) r_mem[b][w_gnt_row[b]] <= w_gnt_wdata[b];
        else             r_q[b]                 <= r_mem[b][w_gnt_row[b]];
      end
    end
  end

  // Each port steers its own response from the bank it read last cycle.
  always_comb begin
    rsp_rdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_rsp_valid[p]) rsp_rdata[p*DATA_W +: DATA_W] = r_q[r_rsp_bank[p]];
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign init_done    = r_init_done;
  assign conflict_cnt = r_conflict;

endmodule

// File: tb/tb_shared_l3_banked.sv
// Self-checking bench for shared_l3_banked with default parameters.
// A flat word-addressed memory model plus per-bank round-robin pointers
// predicts every output; a compare process checks them each falling edge.
module tb_shared_l3_banked;

  localparam int NP    = 2;
  localparam int NB    = 4;
  localparam int DEPTH = 32;
  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int NWORD = NB * DEPTH;

  logic              clk;
  logic              rst;
  logic [NP-1:0]     req_valid;
  logic [NP-1:0]     req_ready;
  logic [NP-1:0]     req_we;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*DW-1:0]  req_wdata;
  logic [NP-1:0]     rsp_valid;
  logic [NP*DW-1:0]  rsp_rdata;
  logic              init_done;
  logic [15:0]       conflict_cnt;

  shared_l3_banked #(
    .NUM_PORTS (NP),
    .NUM_BANKS (NB),
    .BANK_DEPTH(DEPTH),
    .DATA_W    (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .init_done   (init_done),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit check_en = 1'b0;

  // Reference model state
  logic [31:0] m_mem   [NWORD];
  int          m_rr    [NB];
  bit          m_run;
  int          m_fill;
  int          m_cnt;
  logic [NP-1:0] m_rsp_v;
  logic [31:0] m_rsp_d [NP];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
  endtask

  function automatic int addr_of(input int p);
    return int'(req_addr[p*AW +: AW]);
  endfunction

  // Round-robin per bank straight from the rules: first valid port targeting
  // the bank, starting at that bank's pointer and wrapping.
  function automatic logic [NP-1:0] model_grant();
    logic [NP-1:0] g;
    int p;
    g = '0;
    if (!m_run) return g;
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < NP; k++) begin
        p = (m_rr[b] + k) % NP;
        if (req_valid[p] && (addr_of(p) % NB == b)) begin
          g[p] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_fill = 0; m_cnt = 0; m_rsp_v = '0;
    for (int b = 0; b < NB; b++) m_rr[b] = 0;
    for (int p = 0; p < NP; p++) m_rsp_d[p] = '0;
    for (int a = 0; a < NWORD; a++) m_mem[a] = '0;
  endtask

  task automatic model_step();
    logic [NP-1:0] g;
    g = model_grant();
    if (!m_run) begin
      m_rsp_v = '0;
      m_fill++;
      if (m_fill == DEPTH) m_run = 1'b1;
    end else begin
      for (int p = 0; p < NP; p++) begin
        m_rsp_v[p] = g[p] && !req_we[p];
        if (g[p] && !req_we[p]) m_rsp_d[p] = m_mem[addr_of(p)];
      end
      for (int p = 0; p < NP; p++) begin
        if (g[p]) begin
          if (req_we[p]) m_mem[addr_of(p)] = req_wdata[p*DW +: DW];
          m_rr[addr_of(p) % NB] = (p + 1) % NP;
        end
      end
      if (((req_valid & ~g) != '0) && (m_cnt != 65535)) m_cnt++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Compare process: all outputs against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        chk("req_ready", 32'(req_ready), 32'(model_grant()));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
        for (int p = 0; p < NP; p++)
          chk($sformatf("rsp_rdata[%0d]", p), rsp_rdata[p*DW +: DW],
              m_rsp_v[p] ? m_rsp_d[p] : 32'h0);
        chk("init_done", 32'(init_done), 32'(m_run));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    req_we    = '0;
  endtask

  task automatic set_port(input int p, input logic v, input logic we, input int a,
                          input logic [31:0] d);
    req_valid[p]          = v;
    req_we[p]             = we;
    req_addr[p*AW +: AW]  = AW'(a);
    req_wdata[p*DW +: DW] = d;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (DEPTH) tick();
    chk("init_after_reset", 32'(init_done), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    idle();

    // Reset values, with valid requests present during reset.
    #2;
    rst = 1'b1;
    set_port(0, 1'b1, 1'b0, 0, 32'h0);
    set_port(1, 1'b1, 1'b0, 4, 32'h0);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_conflict", 32'(conflict_cnt), 32'd0);
    check_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle();

    // Zero-fill timing: low after 31 edges, high after 32.
    repeat (DEPTH - 1) tick();
    chk("init_low_31", 32'(init_done), 32'd0);
    tick();
    chk("init_high_32", 32'(init_done), 32'd1);

    // Two ports fighting for bank 2: grants alternate 0,1,0,1...
    set_port(0, 1'b1, 1'b0, 2, 32'h0);
    set_port(1, 1'b1, 1'b0, 6, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_alternate", 32'(req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      chk("conflict_step", 32'(conflict_cnt), 32'(i + 1));
    end

    // Write then read-back on port 0.
    do_reset();
    set_port(0, 1'b1, 1'b1, 5, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_ready", 32'(req_ready), 32'd1);
    tick();
    set_port(0, 1'b1, 1'b0, 5, 32'h0);
    @(negedge clk);
    chk("rd_ready", 32'(req_ready), 32'd1);
    tick();
    idle();
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rdata", rsp_rdata[31:0], 32'hDEADBEEF);
    chk("rd_no_conflict", 32'(conflict_cnt), 32'd0);

    // Sweep every address, two ports on adjacent (different) banks.
    for (int a = 0; a < NWORD; a += 2) begin
      set_port(0, 1'b1, 1'b0, a, 32'h0);
      set_port(1, 1'b1, 1'b0, a + 1, 32'h0);
      tick();
    end

    // Parallel reads on banks 0 and 1.
    set_port(0, 1'b1, 1'b0, 4, 32'h0);
    set_port(1, 1'b1, 1'b0, 5, 32'h0);
    @(negedge clk);
    chk("dual_ready", 32'(req_ready), 32'd3);
    tick();
    idle();
    chk("dual_rsp_valid", 32'(rsp_valid), 32'd3);
    chk("dual_rdata0", rsp_rdata[31:0], 32'h0);
    chk("dual_rdata1", rsp_rdata[63:32], 32'hDEADBEEF);

    // Random traffic; first half confined to 16 words to force conflicts.
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++)
        set_port(p, ($urandom % 4) != 0, 1'($urandom % 2),
                 (c < 1500) ? int'($urandom % 16) : int'($urandom % NWORD), $urandom);
      tick();
    end
    idle();
    tick();

    // Reset during a pending read response, then re-init clears the array.
    set_port(0, 1'b1, 1'b1, 9, 32'h1234);
    tick();
    set_port(0, 1'b1, 1'b0, 9, 32'h0);
    tick();
    chk("pend_valid", 32'(rsp_valid), 32'd1);
    chk("pend_rdata", rsp_rdata[31:0], 32'h1234);
    rst = 1'b1;
    idle();
    #1;
    chk("rst_drop_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (DEPTH) tick();
    chk("reinit_done", 32'(init_done), 32'd1);
    set_port(0, 1'b1, 1'b0, 9, 32'h0);
    tick();
    idle();
    chk("reinit_valid", 32'(rsp_valid), 32'd1);
    chk("reinit_rdata", rsp_rdata[31:0], 32'h0);

    // Long-held conflict on bank 0 saturates the counter.
    set_port(0, 1'b1, 1'b0, 0, 32'h0);
    set_port(1, 1'b1, 1'b0, 4, 32'h0);
    repeat (70000) tick();
    chk("conflict_sat", 32'(conflict_cnt), 32'h0000FFFF);
    idle();
    tick();

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shared_l3_banked.md
# shared_l3_banked

Parametrised multi-port, bank-interleaved shared L3 data array; the functional successor to the visual-only L3 bank cluster. Serves NUM_PORTS requesters over valid/ready request channels into NUM_BANKS independent single-port banks, each 32-word RAM32-class with 1-cycle synchronous read. Conflicts are resolved by per-bank round-robin arbitration. After reset, a hardware zero-fill sequence clears all banks before requests are accepted.

## Interface
- NUM_PORTS, 2, requester count (1..8)
- NUM_BANKS, 4, bank count, power of two (1..16)
- BANK_DEPTH, 32, words per bank, power of two
- DATA_W, 32, word width
- Derived (localparam): BANK_W = log2(NUM_BANKS), ROW_W = log2(BANK_DEPTH), ADDR_W = BANK_W + ROW_W

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_PORTS  per-port request valid
- req_ready  out  NUM_PORTS  per-port request accepted this cycle
- req_we  in  NUM_PORTS  1 = write, 0 = read
- req_addr  in  NUM_PORTS*ADDR_W  word address, port p at [p*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_PORTS*DATA_W  write data, port p at [p*DATA_W +: DATA_W]
- rsp_valid  out  NUM_PORTS  read data valid
- rsp_rdata  out  NUM_PORTS*DATA_W  read data, zero whenever rsp_valid[p]=0
- init_done  out  1  zero-fill complete, block in RUN
- conflict_cnt  out  16  saturating count of cycles with at least one stalled valid request while in RUN

## Operation
- Bank select = addr[BANK_W-1:0], row = addr[ADDR_W-1:BANK_W]; consecutive addresses hit consecutive banks.
- FSM states: INIT, RUN.
  - rst asserted -> INIT with row counter 0.
  - INIT: each cycle, write 0 to row counter in every bank, then increment. After row BANK_DEPTH-1 is written -> RUN. req_ready = 0 throughout.
  - RUN: stays until rst.
- Arbitration, per bank, every RUN cycle:
  - Candidates are ports with req_valid=1 whose bank field matches.
  - Grant goes to the first candidate at or after that bank's rr_ptr, scanning upward with wrap.
  - On grant, rr_ptr = granted port + 1, mod NUM_PORTS. rr_ptr is unchanged when there is no grant; reset value 0.
  - At most one grant per bank per cycle; a port may target only one bank, so it gets at most one grant.
- req_ready[p] = granted[p]; it is combinational from req_valid/req_addr (no combinational path from ready back to valid is allowed at the requester).
- Accepted write: bank row <= wdata at that clock edge; no response.
- Accepted read: bank read issued; rsp_valid[p]=1 with data on the next cycle. The bank index is registered per port to steer Q.
- Ports whose req_valid is held low are never stalled and are never counted in conflicts.
- conflict_cnt increments when any port has req_valid=1 and req_ready=0 in RUN. It saturates at 0xFFFF.

## Timing
- Reset values (asynchronous): req_ready 0, rsp_valid 0, rsp_rdata 0, init_done 0, conflict_cnt 0, FSM INIT, all rr_ptr 0.
- Zero-fill takes exactly BANK_DEPTH cycles after rst deasserts; init_done rises on the following edge (default: cycle 32 after first edge).
- Read latency 1 cycle, accept to rsp_valid; throughput 1 request per bank per cycle; aggregate up to min(NUM_PORTS, NUM_BANKS) per cycle.
- Write at edge N followed by a read of the same address accepted at edge N+1 returns the new data.
- Simultaneous read and write to the same address from different ports: only one is granted, and the loser retries. No same-cycle hazard exists.
- rst mid-operation: in-flight read responses are discarded (rsp_valid forced 0 immediately), array contents are re-zeroed, and arbitration state resets.
- No response backpressure: requesters must sink rsp_valid when it arrives.

## Test plan
- Reset then idle -> init_done low for 32 cycles, high at cycle 32; a read of every address (0..127) returns 0.
- Port 0 writes 0xDEADBEEF to addr 5, next cycle reads addr 5 -> rsp_valid[0] one cycle after accept, rsp_rdata = 0xDEADBEEF; conflict_cnt = 0.
- Ports 0 and 1 both read bank 2 continuously -> grants alternate 0,1,0,1 starting with port 0; conflict_cnt increments every cycle.
- Port 0 reads addr 4 (bank 0) and port 1 reads addr 5 (bank 1) in the same cycle -> both req_ready=1; both rsp_valid next cycle with the correct data.
- Hold a conflict for 70000 cycles -> conflict_cnt saturates at 0xFFFF.
- Write 0x1234 to addr 9, pulse rst for 1 cycle during a pending read -> rsp_valid drops at once; after re-init, addr 9 reads 0.
